// File: rtl/uart_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_block_sequencer_if
// Purpose  : FIFO, cipher and status signals of the UART block sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface uart_block_sequencer_if #(
    parameter int BLOCK_BYTES = 8,
    parameter int COUNT_W     = 16
);
    logic                     rx_empty;
    logic [7:0]               rx_data;
    logic                     rd_uart;
    logic                     tx_full;
    logic                     wr_uart;
    logic [7:0]               tx_data;
    logic                     start;
    logic                     flush;
    logic                     mode;
    logic [8*BLOCK_BYTES-1:0] ciph_in;
    logic                     ciph_mode;
    logic                     ciph_start;
    logic [8*BLOCK_BYTES-1:0] ciph_out;
    logic                     ciph_done;
    logic                     busy;
    logic [COUNT_W-1:0]       blk_count;

    // master = the sequencer, slave = FIFOs, cipher and trigger logic
    modport master (
        input  rx_empty, rx_data, tx_full, start, flush, mode, ciph_out, ciph_done,
        output rd_uart, wr_uart, tx_data, ciph_in, ciph_mode, ciph_start, busy, blk_count
    );
    modport slave (
        output rx_empty, rx_data, tx_full, start, flush, mode, ciph_out, ciph_done,
        input  rd_uart, wr_uart, tx_data, ciph_in, ciph_mode, ciph_start, busy, blk_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_block_sequencer
// Purpose  : Packs rx bytes into cipher blocks and drains results to tx
// Revision : 1.0 - initial release
// ============================================================================
module uart_block_sequencer #(
    parameter int         BLOCK_BYTES = 8,
    parameter int         AUTO_START  = 1,
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         COUNT_W     = 16
) (
    input  wire logic              clk_100MHz,
    input  wire logic              reset,
    uart_block_sequencer_if.master bus
);
    localparam int                W        = 8 * BLOCK_BYTES;
    localparam int                CNT_W    = $clog2(BLOCK_BYTES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        WAIT_START = 2'd1,
        CIPHER     = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    state_t             state_q;
    logic [W-1:0]       shift_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [W-1:0]       ciph_in_q;
    logic               ciph_mode_q;
    logic               ciph_start_q;
    logic               busy_q;
    logic [COUNT_W-1:0] blk_count_q;

    logic               pop;
    logic               push;
    logic               blk_ready;
    logic [W-1:0]       fill_shift_d;
    logic [CNT_W-1:0]   fill_cnt_d;
    logic [W-1:0]       padded_d;

    assign pop  = (state_q == FILL)  && !bus.rx_empty;
    assign push = (state_q == DRAIN) && !bus.tx_full;

    // A byte popped together with flush is shifted in before the padding.
    always_comb begin
        fill_shift_d = shift_q;
        fill_cnt_d   = byte_cnt_q;
        if (pop) begin
            fill_shift_d = {shift_q[W-9:0], bus.rx_data};
            fill_cnt_d   = byte_cnt_q + 1'b1;
        end
        padded_d = fill_shift_d;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (k < BLOCK_BYTES - int'(fill_cnt_d)) begin
                padded_d = {padded_d[W-9:0], PAD_BYTE};
            end
        end
    end

    assign blk_ready = (fill_cnt_d == CNT_FULL) || (bus.flush && (fill_cnt_d != '0));

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= FILL;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            ciph_in_q    <= '0;
            ciph_mode_q  <= 1'b0;
            ciph_start_q <= 1'b0;
            busy_q       <= 1'b0;
            blk_count_q  <= '0;
        end else begin
            ciph_start_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (blk_ready) begin
                        shift_q    <= padded_d;
                        byte_cnt_q <= CNT_FULL;
                        busy_q     <= 1'b1;
                        if (AUTO_START != 0) begin
                            state_q      <= CIPHER;
                            ciph_start_q <= 1'b1;
                            ciph_in_q    <= padded_d;
                            ciph_mode_q  <= bus.mode;
                        end else begin
                            state_q <= WAIT_START;
                        end
                    end else begin
                        shift_q    <= fill_shift_d;
                        byte_cnt_q <= fill_cnt_d;
                    end
                end
                WAIT_START: begin
                    if (bus.start) begin
                        state_q      <= CIPHER;
                        ciph_start_q <= 1'b1;
                        ciph_in_q    <= shift_q;
                        ciph_mode_q  <= bus.mode;
                    end
                end
                CIPHER: begin
                    // done may already be high in the start cycle
                    if (bus.ciph_done) begin
                        shift_q    <= bus.ciph_out;
                        byte_cnt_q <= CNT_FULL;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (push) begin
                        shift_q <= {shift_q[W-9:0], 8'h00};
                        if (byte_cnt_q == CNT_ONE) begin
                            byte_cnt_q  <= '0;
                            blk_count_q <= blk_count_q + 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= FILL;
                        end else begin
                            byte_cnt_q <= byte_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.rd_uart    = pop;
    assign bus.wr_uart    = push;
    assign bus.tx_data    = shift_q[W-1 -: 8];
    assign bus.ciph_in    = ciph_in_q;
    assign bus.ciph_mode  = ciph_mode_q;
    assign bus.ciph_start = ciph_start_q;
    assign bus.busy       = busy_q;
    assign bus.blk_count  = blk_count_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_block_sequencer
// Purpose  : Scoreboard bench; unit 0 auto-start/16-bit count, unit 1 manual/2-bit count
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_block_sequencer;
    typedef struct {
        int          n;
        logic [63:0] data;
        int          fl;
        logic        md;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_a[2], start_a[2], flush_a[2], mode_a[2];
    logic        wr_a[2], cst_a[2], cmode_a[2], busy_a[2];
    logic [7:0]  txd_a[2];
    logic [63:0] cin_a[2];
    logic [15:0] cnt_a[2];

    logic [7:0]  rxq[2][$];
    logic [7:0]  expq[2][$];
    logic [63:0] expblk[2][$];
    int          stall_at[2], stall_left[2], lat[2], starts[2], blk_push[2], cwait[2], blk_model[2];
    int          start_cyc[2], first_wr_cyc[2], last_wr_cyc[2], last_pop_cyc[2];
    bit          cact[2], stable_bad[2];
    logic [63:0] held_in[2];
    logic        held_mode[2];
    vec_t        vt[7];

    function automatic logic [63:0] cipher_f(input logic [63:0] b, input logic m);
        return m ? ~b : (b ^ 64'hA5A5_5A5A_0F0F_F0F0);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_unit
        localparam int CW = (g == 0) ? 16 : 2;
        uart_block_sequencer_if #(.BLOCK_BYTES(8), .COUNT_W(CW)) bus ();
        uart_block_sequencer #(
            .BLOCK_BYTES(8), .AUTO_START((g == 0) ? 1 : 0), .PAD_BYTE(8'h00), .COUNT_W(CW)
        ) u_dut (
            .clk_100MHz(clk),
            .reset     (rst_a[g]),
            .bus       (bus)
        );
        assign bus.start  = start_a[g];
        assign bus.flush  = flush_a[g];
        assign bus.mode   = mode_a[g];
        assign wr_a[g]    = bus.wr_uart;
        assign cst_a[g]   = bus.ciph_start;
        assign cmode_a[g] = bus.ciph_mode;
        assign busy_a[g]  = bus.busy;
        assign txd_a[g]   = bus.tx_data;
        assign cin_a[g]   = bus.ciph_in;
        assign cnt_a[g]   = 16'(bus.blk_count);

        // FIFO and cipher model: drive on negedge, observe DUT decisions 1 ns later
        always @(negedge clk) begin : g_env
            logic        full, done;
            logic [7:0]  e8;
            logic [63:0] e64;
            if (cact[g]) begin
                cwait[g]++;
                if (bus.ciph_in !== held_in[g] || bus.ciph_mode !== held_mode[g]) stable_bad[g] = 1'b1;
            end
            done          = (lat[g] == 0) || (cact[g] && cwait[g] >= lat[g]);
            bus.ciph_done = done;
            bus.ciph_out  = done ? cipher_f(bus.ciph_in, bus.ciph_mode) : 64'hDEAD_BEEF_DEAD_BEEF;
            bus.rx_empty  = (rxq[g].size() == 0);
            bus.rx_data   = bus.rx_empty ? 8'h00 : rxq[g][0];
            full          = (stall_left[g] > 0) && (blk_push[g] >= stall_at[g]);
            if (full) stall_left[g]--;
            bus.tx_full   = full;
            #1;
            if (bus.ciph_start) begin
                starts[g]++;
                start_cyc[g]  = cyc;
                held_in[g]    = bus.ciph_in;
                held_mode[g]  = bus.ciph_mode;
                stable_bad[g] = 1'b0;
                cwait[g]      = 0;
                cact[g]       = (lat[g] != 0);
                if (expblk[g].size() > 0) begin
                    e64 = expblk[g].pop_front();
                    check("ciph_in", bus.ciph_in, e64);
                end else begin
                    fail("unexpected_ciph_start");
                end
            end else if (cact[g] && done) begin
                check("ciph_hold_stable", 64'(stable_bad[g]), 64'd0);
                cact[g] = 1'b0;
            end
            if (bus.rd_uart) begin
                last_pop_cyc[g] = cyc;
                if (rxq[g].size() == 0) fail("pop_while_empty");
                else e8 = rxq[g].pop_front();
            end
            if (bus.wr_uart) begin
                if (full) fail("push_while_full");
                blk_push[g]++;
                if (blk_push[g] == 1) first_wr_cyc[g] = cyc;
                last_wr_cyc[g] = cyc;
                if (expq[g].size() > 0) begin
                    e8 = expq[g].pop_front();
                    check("tx_data", 64'(bus.tx_data), 64'(e8));
                end else begin
                    fail("unexpected_push");
                end
                if (blk_push[g] == 8) blk_push[g] = 0;
            end
        end
    end

    task automatic wait_rx(input int g, input int k);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxq[g].size() == k) return;
        end
        fail("timeout_rx");
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_a[g] && expq[g].size() == 0 && rxq[g].size() == 0) return;
        end
        fail("timeout_idle");
    endtask

    task automatic pulse_flush(input int g);
        flush_a[g] = 1'b1;
        @(negedge clk);
        flush_a[g] = 1'b0;
    endtask

    task automatic pulse_start(input int g);
        start_a[g] = 1'b1;
        @(negedge clk);
        start_a[g] = 1'b0;
    endtask

    // fl: 0 none, 1 flush after the last pop, 2 flush together with the last pop
    task automatic send(input int g, input int n, input logic [63:0] data, input int fl,
                        input logic md, input logic [63:0] exp);
        logic [63:0] r;
        mode_a[g] = md;
        for (int i = 0; i < n; i++) rxq[g].push_back(data[63-8*i -: 8]);
        expblk[g].push_back(exp);
        r = cipher_f(exp, md);
        for (int i = 0; i < 8; i++) expq[g].push_back(r[63-8*i -: 8]);
        if (fl == 1) begin
            wait_rx(g, 0);
            pulse_flush(g);
        end else if (fl == 2) begin
            wait_rx(g, 1);
            pulse_flush(g);
        end
    endtask

    task automatic do_reset(input int g);
        @(negedge clk);
        rst_a[g] = 1'b1;
        @(negedge clk);
        rst_a[g] = 1'b0;
        expq[g].delete();
        expblk[g].delete();
        blk_push[g]   = 0;
        stall_left[g] = 0;
        stall_at[g]   = 99;
        cact[g]       = 1'b0;
        blk_model[g]  = 0;
        check("rst_busy", 64'(busy_a[g]), 64'd0);
        check("rst_blk_count", 64'(cnt_a[g]), 64'd0);
        check("rst_tx_data", 64'(txd_a[g]), 64'd0);
        check("rst_wr_uart", 64'(wr_a[g]), 64'd0);
        check("rst_ciph_start", 64'(cst_a[g]), 64'd0);
        check("rst_ciph_in", cin_a[g], 64'd0);
        check("rst_ciph_mode", 64'(cmode_a[g]), 64'd0);
    endtask

    initial begin
        #1_000_000;
        fail("watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        for (int g = 0; g < 2; g++) begin
            rst_a[g] = 1'b1; start_a[g] = 1'b0; flush_a[g] = 1'b0; mode_a[g] = 1'b0;
            stall_at[g] = 99; stall_left[g] = 0; lat[g] = 0; starts[g] = 0; blk_push[g] = 0;
            cwait[g] = 0; cact[g] = 1'b0; stable_bad[g] = 1'b0; blk_model[g] = 0;
        end
        vt[0] = '{8, 64'h0102030405060708, 0, 1'b1, 64'h0102030405060708};
        vt[1] = '{3, 64'hAABBCC0000000000, 1, 1'b1, 64'hAABBCC0000000000};
        vt[2] = '{8, 64'hDEADBEEFCAFEF00D, 0, 1'b0, 64'hDEADBEEFCAFEF00D};
        vt[3] = '{1, 64'h5A00000000000000, 1, 1'b0, 64'h5A00000000000000};
        vt[4] = '{2, 64'h1234000000000000, 2, 1'b1, 64'h1234000000000000};
        vt[5] = '{8, 64'h8877665544332211, 2, 1'b1, 64'h8877665544332211};
        vt[6] = '{7, 64'h1122334455667700, 1, 1'b0, 64'h1122334455667700};

        repeat (3) @(negedge clk);
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;
        @(negedge clk);
        check("init_busy", 64'(busy_a[0]), 64'd0);
        check("init_blk_count", 64'(cnt_a[0]), 64'd0);
        check("init_ciph_in", cin_a[0], 64'd0);
        check("init_ciph_start", 64'(cst_a[0]), 64'd0);
        check("init_tx_data", 64'(txd_a[0]), 64'd0);
        check("init_busy_manual", 64'(busy_a[1]), 64'd0);

        for (int i = 0; i < 7; i++) begin
            send(0, vt[i].n, vt[i].data, vt[i].fl, vt[i].md, vt[i].exp);
            wait_idle(0);
            blk_model[0]++;
            check("blk_count", 64'(cnt_a[0]), 64'(blk_model[0]));
            if (i == 0) begin
                check("lat_start", 64'(start_cyc[0] - last_pop_cyc[0]), 64'd1);
                check("lat_first_wr", 64'(first_wr_cyc[0] - last_pop_cyc[0]), 64'd2);
                check("drain_span", 64'(last_wr_cyc[0] - first_wr_cyc[0]), 64'd7);
            end
        end

        c = starts[0];
        @(negedge clk);
        pulse_flush(0);
        repeat (20) @(negedge clk);
        check("flush_empty_starts", 64'(starts[0]), 64'(c));
        check("flush_empty_busy", 64'(busy_a[0]), 64'd0);

        stall_at[0]   = 3;
        stall_left[0] = 20;
        send(0, 8, 64'hC0C1C2C3C4C5C6C7, 0, 1'b1, 64'hC0C1C2C3C4C5C6C7);
        wait_idle(0);
        blk_model[0]++;
        check("stall_consumed", 64'(stall_left[0]), 64'd0);
        check("stall_drain_span", 64'(last_wr_cyc[0] - first_wr_cyc[0]), 64'd27);
        check("stall_blk_count", 64'(cnt_a[0]), 64'(blk_model[0]));
        stall_at[0] = 99;

        lat[0] = 40;
        c = starts[0];
        send(0, 8, 64'h0F1E2D3C4B5A6978, 0, 1'b1, 64'h0F1E2D3C4B5A6978);
        for (int i = 0; i < 100 && starts[0] == c; i++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            mode_a[0] = ~mode_a[0];
        end
        wait_idle(0);
        blk_model[0]++;
        check("slow_cipher_latency", 64'(first_wr_cyc[0] - start_cyc[0]), 64'd41);
        check("slow_blk_count", 64'(cnt_a[0]), 64'(blk_model[0]));
        lat[0] = 0;

        for (int i = 0; i < 5; i++) rxq[0].push_back(8'(8'h90 + i));
        wait_rx(0, 0);
        do_reset(0);
        send(0, vt[0].n, vt[0].data, 0, 1'b1, vt[0].exp);
        wait_idle(0);
        blk_model[0]++;
        check("after_fill_reset_count", 64'(cnt_a[0]), 64'd1);

        stall_at[0]   = 3;
        stall_left[0] = 100000;
        send(0, 8, 64'h2122232425262728, 0, 1'b1, 64'h2122232425262728);
        for (int i = 0; i < 200 && blk_push[0] != 3; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        do_reset(0);
        send(0, 8, 64'h3132333435363738, 0, 1'b0, 64'h3132333435363738);
        wait_idle(0);
        blk_model[0]++;
        check("after_drain_reset_count", 64'(cnt_a[0]), 64'd1);

        send(1, 8, 64'hA1A2A3A4A5A6A7A8, 0, 1'b1, 64'hA1A2A3A4A5A6A7A8);
        wait_rx(1, 0);
        repeat (100) @(negedge clk);
        check("manual_no_start", 64'(starts[1]), 64'd0);
        check("manual_busy", 64'(busy_a[1]), 64'd1);
        c = cyc;
        pulse_start(1);
        wait_idle(1);
        blk_model[1]++;
        check("manual_start_latency", 64'(start_cyc[1] - c), 64'd1);
        for (int b = 1; b < 5; b++) begin
            send(1, 8, 64'h0011223344556677 ^ (64'h0101010101010101 * 64'(b)), 0, 1'b0,
                 64'h0011223344556677 ^ (64'h0101010101010101 * 64'(b)));
            wait_rx(1, 0);
            @(negedge clk);
            pulse_start(1);
            wait_idle(1);
            blk_model[1]++;
        end
        check("blk_count_wrap", 64'(cnt_a[1]), 64'(blk_model[1] % 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
